// File: rtl/pow_arb_2x.sv
// pow_arb_2x: two requester streams share one fixed-latency power engine.
// Round-robin issue gated by per-channel credits; results steered by tag
// into per-channel output FIFOs, so the engine is never back-pressured.
// Ports:
//   clk, aresetn                 clock, async active-low reset
//   s0_*/s1_* (tvalid,tready,tdata)  requester inputs
//   e_* (tvalid,tready,tdata,tid)    issue to engine
//   e_r_* (tvalid,tready,tdata,tid)  engine results
//   m0_*/m1_* (tvalid,tready,tdata)  per-channel results
// Build option: POW_ARB_STRICT_PRIO_EN selects fixed ch0 priority
// instead of round-robin.
module pow_arb_2x #(
  parameter int DATA_W     = 32,
  parameter int LAT        = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  output logic              e_tvalid,
  input  logic              e_tready,
  output logic [DATA_W-1:0] e_tdata,
  output logic              e_tid,
  input  logic              e_r_tvalid,
  output logic              e_r_tready,
  input  logic [DATA_W-1:0] e_r_tdata,
  input  logic              e_r_tid,
  output logic              m0_tvalid,
  input  logic              m0_tready,
  output logic [DATA_W-1:0] m0_tdata,
  output logic              m1_tvalid,
  input  logic              m1_tready,
  output logic [DATA_W-1:0] m1_tdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || LAT < 1) begin : g_bad_cfg
    $error("pow_arb_2x: FIFO_DEPTH >= 2 and LAT >= 1 required");
  end

  logic [1:0]        s_tvalid;
  logic [1:0]        m_tready;
  logic [1:0]        elig;
  logic [1:0]        iss;
  logic [1:0]        pop;
  logic [1:0]        empty;
  logic [DATA_W-1:0] m_tdata [2];
  logic [CW-1:0]     cred [2];
  logic              win;
  logic              hs;

  assign s_tvalid = {s1_tvalid, s0_tvalid};
  assign m_tready = {m1_tready, m0_tready};

  // credits = beats in the engine + beats parked in the FIFO
  assign elig[0] = s_tvalid[0] && (cred[0] < CW'(FIFO_DEPTH));
  assign elig[1] = s_tvalid[1] && (cred[1] < CW'(FIFO_DEPTH));

`ifdef POW_ARB_STRICT_PRIO_EN
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      !elig[0] && elig[1]: win = 1'b1;
      default:             win = 1'b0;
    endcase
  end
`else
  logic rr_ptr;

  // rr_ptr is the last-served channel; on contention the other one wins
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      elig[0] && elig[1]:  win = ~rr_ptr;
      !elig[0] && elig[1]: win = 1'b1;
      default:             win = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr <= 1'b0;
    end else if (hs) begin
      rr_ptr <= win;
    end
  end
`endif

  assign e_tvalid  = |elig;
  assign e_tid     = win;
  assign e_tdata   = win ? s1_tdata : s0_tdata;
  assign hs        = e_tvalid && e_tready;
  assign s0_tready = hs && !win;
  assign s1_tready = hs && win;
  assign iss       = {hs && win, hs && !win};

  assign e_r_tready = aresetn;

  for (genvar n = 0; n < 2; n++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [CW-1:0]     wp;
    logic [CW-1:0]     rp;
    logic              full;
    logic              wr_req;
    logic              wr;

    assign empty[n] = (wp == rp);
    assign full     = (wp[AW] != rp[AW])
                   && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop[n]   = !empty[n] && m_tready[n];
    assign wr_req   = e_r_tvalid && (e_r_tid == 1'(n));
    // a pop in the same cycle frees the slot being written
    assign wr       = wr_req && (!full || pop[n]);

    always_ff @(posedge clk) begin
      if (wr) begin
        mem[wp[AW-1:0]] <= e_r_tdata;
      end
    end

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (wr) begin
          wp <= wp + 1'b1;
        end
        if (pop[n]) begin
          rp <= rp + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        cred[n] <= '0;
      end else begin
        unique case ({iss[n], pop[n]})
          2'b10:   cred[n] <= cred[n] + 1'b1;
          2'b01:   cred[n] <= cred[n] - 1'b1;
          default: cred[n] <= cred[n];
        endcase
      end
    end

    assign m_tdata[n] = empty[n] ? '0 : mem[rp[AW-1:0]];

    a_no_ovf: assert property (
      @(posedge clk) disable iff (!aresetn)
      !(wr_req && full && !pop[n]));
  end

  assign m0_tvalid = !empty[0];
  assign m1_tvalid = !empty[1];
  assign m0_tdata  = m_tdata[0];
  assign m1_tdata  = m_tdata[1];

endmodule

// File: tb/tb_pow_arb_2x.sv
// tb_pow_arb_2x: scoreboard bench for pow_arb_2x with a squaring
// engine model, directed scenarios and a randomized soak.
module tb_pow_arb_2x;

  localparam int DW  = 32;
  localparam int LAT = 5;
  localparam int D   = 8;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s0_tvalid = 1'b0, s0_tready;
  logic [DW-1:0] s0_tdata = '0;
  logic          s1_tvalid = 1'b0, s1_tready;
  logic [DW-1:0] s1_tdata = '0;
  logic          e_tvalid, e_tid;
  logic          e_tready = 1'b1;
  logic [DW-1:0] e_tdata;
  logic          e_r_tvalid, e_r_tready, e_r_tid;
  logic [DW-1:0] e_r_tdata;
  logic          m0_tvalid, m1_tvalid;
  logic          m0_tready = 1'b1, m1_tready = 1'b1;
  logic [DW-1:0] m0_tdata, m1_tdata;

  pow_arb_2x #(.DATA_W(DW), .LAT(LAT), .FIFO_DEPTH(D)) dut (
    .clk(clk), .aresetn(aresetn),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
    .e_tvalid(e_tvalid), .e_tready(e_tready), .e_tdata(e_tdata),
    .e_tid(e_tid),
    .e_r_tvalid(e_r_tvalid), .e_r_tready(e_r_tready),
    .e_r_tdata(e_r_tdata), .e_r_tid(e_r_tid),
    .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tdata(m0_tdata),
    .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tdata(m1_tdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_data = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // engine: fixed LAT cycles, squares the operand, echoes the tag
  logic          pv [LAT];
  logic          pt [LAT];
  logic [DW-1:0] pd [LAT];
  logic          cap_v, cap_t;
  logic [DW-1:0] cap_d;

  always @(negedge clk) begin
    cap_v = aresetn && e_tvalid && e_tready;
    cap_d = e_tdata * e_tdata;
    cap_t = e_tid;
  end

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= cap_v;
      pd[0] <= cap_d;
      pt[0] <= cap_t;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
        pt[i] <= pt[i-1];
      end
    end
  end

  assign e_r_tvalid = pv[LAT-1];
  assign e_r_tdata  = pd[LAT-1];
  assign e_r_tid    = pt[LAT-1];

  // reference model: credit counts, last-served channel, expected results
  int            m_cred [2];
  int            acc [2];
  bit            m_rr;
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];

  always @(negedge clk) begin
    bit el0, el1, ev, w;
    logic [DW-1:0] d;
    if (!aresetn) begin
      m_cred[0] = 0;
      m_cred[1] = 0;
      m_rr = 1'b0;
      q0.delete();
      q1.delete();
    end else begin
      el0 = s0_tvalid && (m_cred[0] < D);
      el1 = s1_tvalid && (m_cred[1] < D);
      ev  = el0 || el1;
`ifdef POW_ARB_STRICT_PRIO_EN
      w = !el0;
`else
      w = (el0 && el1) ? !m_rr : el1;
`endif
      chk("e_tvalid", e_tvalid, ev);
      chk("s0_tready", s0_tready, ev && !w);
      chk("s1_tready", s1_tready, ev && w);
      if (ev) begin
        d = w ? s1_tdata : s0_tdata;
        chk("e_tid", e_tid, w);
        chk("e_tdata", e_tdata, d);
        if (w) q1.push_back(d * d);
        else   q0.push_back(d * d);
        m_rr = w;
        m_cred[w]++;
        acc[w]++;
      end
      if (m0_tvalid && m0_tready && m_cred[0] > 0) m_cred[0]--;
      if (m1_tvalid && m1_tready && m_cred[1] > 0) m_cred[1]--;
    end
  end

  // monitor: compares every delivered result against the scoreboard
  always @(negedge clk) begin
    if (aresetn) begin
      if (m0_tvalid && m0_tready) begin
        if (q0.size() == 0) chk("m0_unexpected", 1, 0);
        else chk("m0_tdata", m0_tdata, q0.pop_front());
      end
      if (m1_tvalid && m1_tready) begin
        if (q1.size() == 0) chk("m1_unexpected", 1, 0);
        else chk("m1_tdata", m1_tdata, q1.pop_front());
      end
    end
  end

  task automatic step();
    bit h0, h1;
    @(negedge clk);
    h0 = s0_tvalid && s0_tready;
    h1 = s1_tvalid && s1_tready;
    @(posedge clk);
    #1;
    if (rnd_data && h0) s0_tdata = $urandom;
    if (rnd_data && h1) s1_tdata = $urandom;
  endtask

  task automatic drain();
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    m0_tready = 1'b1;
    m1_tready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    chk("drain", q0.size() + q1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, a1;
    bit saw1, got;
    // 1: reset values, single beat latency
    s0_tvalid = 1'b1;
    @(negedge clk);
    chk("rst_m0_tvalid", m0_tvalid, 0);
    chk("rst_m1_tvalid", m1_tvalid, 0);
    chk("rst_m0_tdata", m0_tdata, 0);
    chk("rst_m1_tdata", m1_tdata, 0);
    chk("rst_e_r_tready", e_r_tready, 0);
    @(posedge clk);
    #1;
    s0_tvalid = 1'b0;
    aresetn = 1'b1;
    @(negedge clk);
    chk("e_r_tready_run", e_r_tready, 1);
    @(posedge clk);
    #1;
    rnd_data = 1'b0;
    s0_tvalid = 1'b1;
    s0_tdata = 3;
    @(negedge clk);
    chk("p1_e_tid", e_tid, 0);
    t0 = cyc;
    @(posedge clk);
    #1;
    s0_tvalid = 1'b0;
    saw1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m1_tvalid) saw1 = 1'b1;
      if (m0_tvalid) begin
        got = 1'b1;
        break;
      end
    end
    chk("p1_timeout", got, 1);
    chk("p1_latency", cyc - t0, LAT + 1);
    chk("p1_m0_tdata", m0_tdata, 9);
    chk("p1_m1_quiet", saw1, 0);
    @(posedge clk);
    #1;
    // 2: contention from reset, fixed data
    do_reset();
    s0_tvalid = 1'b1;
    s0_tdata = 2;
    s1_tvalid = 1'b1;
    s1_tdata = 5;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
`ifdef POW_ARB_STRICT_PRIO_EN
      chk("p2_grant", e_tid, 0);
`else
      chk("p2_grant", e_tid, (i % 2 == 0) ? 1 : 0);
`endif
      @(posedge clk);
      #1;
    end
    drain();
    // 3: stalled m1 stops ch1 after D credits, ch0 keeps going
    rnd_data = 1'b1;
    acc[0] = 0;
    acc[1] = 0;
    m1_tready = 1'b0;
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    repeat (30) step();
`ifdef POW_ARB_STRICT_PRIO_EN
    chk("p3_acc1", acc[1], 0);
    chk("p3_acc0", acc[0], 30);
`else
    chk("p3_acc1", acc[1], D);
    chk("p3_acc0", acc[0], 30 - D);
    @(negedge clk);
    chk("p3_s1_stalled", s1_tready, 0);
    @(posedge clk);
    #1;
`endif
    s0_tvalid = 1'b0;
    m1_tready = 1'b1;
    a1 = acc[1];
    repeat (12) step();
    chk("p3_resume", acc[1] > a1, 1);
    drain();
    // 4: issue and pop on ch0 with credits exhausted
    acc[0] = 0;
    m0_tready = 1'b0;
    s0_tvalid = 1'b1;
    repeat (20) step();
    chk("p4_acc0", acc[0], D);
    m0_tready = 1'b1;
    @(negedge clk);
    chk("p4_m0_full", m0_tvalid, 1);
    chk("p4_no_issue", s0_tready, 0);
    @(posedge clk);
    #1;
    m0_tready = 1'b0;
    @(negedge clk);
    chk("p4_issue_ok", s0_tready, 1);
    @(posedge clk);
    #1;
    drain();
    // 5: reset with beats in flight
    rnd_data = 1'b0;
    s0_tdata = 7;
    s0_tvalid = 1'b1;
    repeat (3) step();
    s0_tvalid = 1'b0;
    step();
    aresetn = 1'b0;
    @(negedge clk);
    chk("p5_m0_tvalid", m0_tvalid, 0);
    chk("p5_m1_tvalid", m1_tvalid, 0);
    chk("p5_m0_tdata", m0_tdata, 0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (10) step();
    chk("p5_flushed", m0_tvalid, 0);
    s0_tdata = 4;
    s0_tvalid = 1'b1;
    @(negedge clk);
    chk("p5_issue", s0_tready, 1);
    @(posedge clk);
    #1;
    s0_tvalid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_tvalid) begin
        got = 1'b1;
        break;
      end
    end
    chk("p5_timeout", got, 1);
    chk("p5_m0_tdata", m0_tdata, 16);
    @(posedge clk);
    #1;
    drain();
    // 6: randomized soak
    rnd_data = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit h0, h1;
      @(negedge clk);
      h0 = s0_tvalid && s0_tready;
      h1 = s1_tvalid && s1_tready;
      @(posedge clk);
      #1;
      if (!s0_tvalid || h0) begin
        s0_tvalid = ($urandom_range(0, 3) != 0);
        s0_tdata = $urandom;
      end
      if (!s1_tvalid || h1) begin
        s1_tvalid = ($urandom_range(0, 3) != 0);
        s1_tdata = $urandom;
      end
      m0_tready = ($urandom_range(0, 3) != 0);
      m1_tready = ($urandom_range(0, 9) < 3);
    end
    drain();
    chk("end_m0_idle", m0_tvalid, 0);
    chk("end_m1_idle", m1_tvalid, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
